// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the I-memory request and next PC, and owns the IF/ID latch.
// Defining FETCH_PERF_EN adds fetch_miss_cnt_o, a saturating count of I-memory miss cycles.
module fetch_unit #(
  parameter int unsigned PC_STEP   = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc_i,
  output logic [31:0] next_pc_o,
  output logic        pc_en_o,
  output logic        imem_ren_o,
  output logic [31:0] imem_addr_o,
  input  logic        ihit_i,
  input  logic [31:0] imem_load_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_stall_i,
  input  logic        halt_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_o,
`ifdef FETCH_PERF_EN
  output logic [31:0] ifid_npc_o,
  output logic [31:0] fetch_miss_cnt_o
`else
  output logic [31:0] ifid_npc_o
`endif
);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] REDIR_PEND = 2'd1;
  localparam logic [1:0] HALTED     = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] seq_pc;

  assign seq_pc      = pc_i + 32'(PC_STEP);
  assign imem_addr_o = pc_i;
  assign imem_ren_o  = (state_q != HALTED);

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    pc_en_o   = 1'b0;
    next_pc_o = pc_i;
    valid_d   = 1'b0;
    instr_d   = NOP_INSTR;
    pc_d      = 32'h0;
    npc_d     = 32'h0;

    case (state_q)
      RUN: begin
        if (halt_i) begin
          state_d = HALTED;
        end else if (redirect_i) begin
          if (ihit_i) begin
            pc_en_o   = 1'b1;
            next_pc_o = redirect_pc_i;
          end else begin
            pend_pc_d = redirect_pc_i;
            state_d   = REDIR_PEND;
          end
        end else if (id_stall_i) begin
          valid_d = valid_q;
          instr_d = instr_q;
          pc_d    = pc_q;
          npc_d   = npc_q;
        end else if (ihit_i) begin
          pc_en_o   = 1'b1;
          next_pc_o = seq_pc;
          valid_d   = 1'b1;
          instr_d   = imem_load_i;
          pc_d      = pc_i;
          npc_d     = seq_pc;
        end
      end
      REDIR_PEND: begin
        // IF/ID is a bubble here, so a decode stall has nothing to hold.
        if (halt_i) begin
          state_d = HALTED;
        end else begin
          if (redirect_i) pend_pc_d = redirect_pc_i;
          if (ihit_i) begin
            pc_en_o   = 1'b1;
            next_pc_o = redirect_i ? redirect_pc_i : pend_pc_q;
            state_d   = RUN;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= RUN;
      pend_pc_q <= 32'h0;
      valid_q   <= 1'b0;
      instr_q   <= NOP_INSTR;
      pc_q      <= 32'h0;
      npc_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      npc_q     <= npc_d;
    end
  end

  assign ifid_valid_o = valid_q;
  assign ifid_instr_o = instr_q;
  assign ifid_pc_o    = pc_q;
  assign ifid_npc_o   = npc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] miss_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      miss_cnt_q <= 32'h0;
    end else if (imem_ren_o && !ihit_i && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign fetch_miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model queues expected outputs per cycle and
// independent monitors compare combinational outputs and IF/ID contents.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] next_pc;
    logic        pc_en;
    logic        ren;
    logic [31:0] addr;
  } comb_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] cnt;
  } ifid_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic [31:0] pc_i, next_pc_o, imem_addr_o, imem_load_i, redirect_pc_i;
  logic        pc_en_o, imem_ren_o, ihit_i, redirect_i, id_stall_i, halt_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_instr_o, ifid_pc_o, ifid_npc_o;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_miss_cnt_o;
`endif

  always #5 CLK = ~CLK;

  fetch_unit dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .pc_i          (pc_i),
    .next_pc_o     (next_pc_o),
    .pc_en_o       (pc_en_o),
    .imem_ren_o    (imem_ren_o),
    .imem_addr_o   (imem_addr_o),
    .ihit_i        (ihit_i),
    .imem_load_i   (imem_load_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_stall_i    (id_stall_i),
    .halt_i        (halt_i),
    .ifid_valid_o  (ifid_valid_o),
    .ifid_instr_o  (ifid_instr_o),
    .ifid_pc_o     (ifid_pc_o),
`ifdef FETCH_PERF_EN
    .ifid_npc_o    (ifid_npc_o),
    .fetch_miss_cnt_o (fetch_miss_cnt_o)
`else
    .ifid_npc_o    (ifid_npc_o)
`endif
  );

  comb_t comb_q[$];
  ifid_t ifid_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model: a halted flag, a pending-redirect flag with its target, and the latch.
  bit          m_halted  = 1'b0;
  bit          m_pending = 1'b0;
  logic [31:0] m_target  = 32'h0;
  ifid_t       m_ifid    = '0;
  logic [31:0] m_cnt     = 32'h0;
  logic [31:0] tb_pc     = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic drive(input bit h, input bit r, input logic [31:0] rp, input bit s,
                       input bit hit, input logic [31:0] ld);
    comb_t ce;
    ifid_t bub;
    ifid_t ie;
    halt_i        = h;
    redirect_i    = r;
    redirect_pc_i = rp;
    id_stall_i    = s;
    ihit_i        = hit;
    imem_load_i   = ld;
    pc_i          = tb_pc;
    bub           = '0;
    bub.instr     = NOP;
    ce.ren        = !m_halted;
    ce.addr       = tb_pc;
    ce.pc_en      = 1'b0;
    ce.next_pc    = tb_pc;
    if (!m_halted && !hit && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (m_halted) begin
      m_ifid = bub;
    end else if (m_pending) begin
      m_ifid = bub;
      if (h) begin
        m_halted  = 1'b1;
        m_pending = 1'b0;
      end else begin
        if (r) m_target = rp;
        if (hit) begin
          ce.pc_en   = 1'b1;
          ce.next_pc = m_target;
          m_pending  = 1'b0;
        end
      end
    end else if (h) begin
      m_halted = 1'b1;
      m_ifid   = bub;
    end else if (r) begin
      m_ifid = bub;
      if (hit) begin
        ce.pc_en   = 1'b1;
        ce.next_pc = rp;
      end else begin
        m_pending = 1'b1;
        m_target  = rp;
      end
    end else if (!s) begin
      if (hit) begin
        ce.pc_en   = 1'b1;
        ce.next_pc = tb_pc + 32'd4;
        m_ifid     = '{valid: 1'b1, instr: ld, pc: tb_pc, npc: tb_pc + 32'd4, cnt: 32'h0};
      end else begin
        m_ifid = bub;
      end
    end
    comb_q.push_back(ce);
    ie     = m_ifid;
    ie.cnt = m_cnt;
    ifid_q.push_back(ie);
    if (ce.pc_en) tb_pc = ce.next_pc;
  endtask

  // Called at a falling edge: a miss cycle with reset asserted across the following rising edge.
  task automatic reset_pulse();
    ifid_t bub;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, $urandom);
    bub       = '0;
    bub.instr = NOP;
    void'(ifid_q.pop_back());
    ifid_q.push_back(bub);
    m_halted  = 1'b0;
    m_pending = 1'b0;
    m_ifid    = bub;
    m_cnt     = 32'h0;
    #3 nRST = 1'b0;
    #5 nRST = 1'b1;
  endtask

  initial begin : comb_monitor
    comb_t ce;
    forever begin
      @(negedge CLK);
      #2;
      if (comb_q.size() != 0) begin
        ce = comb_q.pop_front();
        chk("next_pc", next_pc_o, ce.next_pc);
        chk("pc_en", {31'h0, pc_en_o}, {31'h0, ce.pc_en});
        chk("imem_ren", {31'h0, imem_ren_o}, {31'h0, ce.ren});
        chk("imem_addr", imem_addr_o, ce.addr);
      end
    end
  end

  initial begin : ifid_monitor
    ifid_t ie;
    forever begin
      @(posedge CLK);
      #1;
      if (ifid_q.size() != 0) begin
        ie = ifid_q.pop_front();
        chk("ifid_valid", {31'h0, ifid_valid_o}, {31'h0, ie.valid});
        chk("ifid_instr", ifid_instr_o, ie.instr);
        chk("ifid_pc", ifid_pc_o, ie.pc);
        chk("ifid_npc", ifid_npc_o, ie.npc);
`ifdef FETCH_PERF_EN
        chk("miss_cnt", fetch_miss_cnt_o, ie.cnt);
`endif
      end
    end
  end

  initial begin : stimulus
    halt_i = 0; redirect_i = 0; redirect_pc_i = 0; id_stall_i = 0; ihit_i = 0;
    imem_load_i = 0; pc_i = 0;
    #1 nRST = 1'b0;
    @(negedge CLK) reset_pulse();

    tb_pc = 32'h0;
    repeat (3) @(negedge CLK) drive(0, 0, 32'h0, 0, 1, $urandom);
    tb_pc = 32'h40;
    repeat (2) @(negedge CLK) drive(0, 0, 32'h0, 0, 0, $urandom);
    @(negedge CLK) drive(0, 0, 32'h0, 0, 1, $urandom);
    @(negedge CLK) drive(0, 1, 32'h100, 0, 1, $urandom);
    @(negedge CLK) drive(0, 1, 32'h200, 0, 0, $urandom);
    @(negedge CLK) drive(0, 1, 32'h300, 0, 0, $urandom);
    @(negedge CLK) drive(0, 0, 32'h0, 0, 1, $urandom);
    @(negedge CLK) drive(0, 0, 32'h0, 0, 1, $urandom);
    @(negedge CLK) drive(0, 0, 32'h0, 1, 1, $urandom);
    @(negedge CLK) drive(0, 1, 32'h500, 1, 1, $urandom);
    @(negedge CLK) drive(1, 0, 32'h0, 0, 1, $urandom);
    repeat (4) @(negedge CLK) drive(0, $urandom_range(0, 1), $urandom, 0, $urandom_range(0, 1),
                                    $urandom);
    @(negedge CLK) reset_pulse();
    repeat (5) @(negedge CLK) drive(0, 0, 32'h0, 0, 0, $urandom);
    @(negedge CLK) drive(0, 0, 32'h0, 0, 1, $urandom);

    for (int e = 0; e < 8; e++) begin
      for (int i = 0; i < 300; i++) begin
        @(negedge CLK) drive($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                             $urandom & 32'hFFFF_FFFC, $urandom_range(0, 4) == 0,
                             $urandom_range(0, 2) != 0, $urandom);
      end
      @(negedge CLK) reset_pulse();
    end

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
